// File: rtl/result_writer_pkg.sv
// Shared constants, FSM state encoding and helpers for the result writer
// and its sibling img2col blocks. Tile dimension must be a power of two:
// tile counts and tile-relative indices are formed by shifts and concatenation.
package result_writer_pkg;

    localparam int S2P_SIZE    = 4;
    localparam int RESULT_SIZE = 32;
    localparam int ADDR_W      = 16;
    localparam int PIX_W       = 12;
    localparam int KN_W        = 8;
    localparam int LOG2_N      = $clog2(S2P_SIZE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } rw_state_e;

    // Number of N-wide tiles covering n pixels: ceil(n / N) via add and shift.
    function automatic logic [PIX_W-1:0] pix_tiles(input logic [PIX_W-1:0] n);
        logic [PIX_W:0] sum_v;
        sum_v = {1'b0, n} + (PIX_W+1)'(S2P_SIZE - 1);
        return PIX_W'(sum_v >> LOG2_N);
    endfunction

    // Number of N-wide tiles covering n kernels: ceil(n / N) via add and shift.
    function automatic logic [KN_W-1:0] kn_tiles(input logic [KN_W-1:0] n);
        logic [KN_W:0] sum_v;
        sum_v = {1'b0, n} + (KN_W+1)'(S2P_SIZE - 1);
        return KN_W'(sum_v >> LOG2_N);
    endfunction

    // Clamp negative (MSB set) results to zero.
    function automatic logic [RESULT_SIZE-1:0] relu_word(input logic [RESULT_SIZE-1:0] d);
        logic [RESULT_SIZE-1:0] r_v;
        if (d[RESULT_SIZE-1]) begin
            r_v = {RESULT_SIZE{1'b0}};
        end else begin
            r_v = d;
        end
        return r_v;
    endfunction

endpackage

// File: rtl/result_writer_addr_gen.sv
// result_addr_gen: beat counters (p, k, tt, wt) and incremental address
// generation for the result writer. Channel bases are kept as running sums
// so no multiplier is needed; padded positions are flagged via wr_mask.
module result_addr_gen
    import result_writer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [PIX_W-1:0]  cfg_out_pixels,
    input  logic [KN_W-1:0]   cfg_kernel_nums,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic              beat,
    input  logic              tile_start,
    output logic [ADDR_W-1:0] addr,
    output logic              wr_mask,
    output logic              last_beat,
    output logic              misalign
);

    localparam logic [LOG2_N-1:0] P_ZERO = {LOG2_N{1'b0}};
    localparam logic [LOG2_N-1:0] P_ONE  = LOG2_N'(1);
    localparam logic [LOG2_N-1:0] P_MAX  = LOG2_N'(S2P_SIZE - 1);

    logic [LOG2_N-1:0]        p_r, k_r;
    logic [PIX_W-1:0]         tt_r, t_tiles_r, op_r;
    logic [KN_W-1:0]          wt_r, w_tiles_r, kn_r;
    logic [ADDR_W-1:0]        ch_base_r, wt_base_r, step_n_r;

    logic                     resync_s;
    logic [LOG2_N-1:0]        p_eff_s, k_eff_s;
    logic [ADDR_W-1:0]        cb_eff_s;
    logic [PIX_W+LOG2_N-1:0]  pix_s;
    logic [KN_W+LOG2_N-1:0]   kidx_s;
    logic                     p_end_s, k_end_s, tt_end_s, wt_end_s;

    // Effective position of the current beat (a misplaced tile-start snaps it
    // back to pixel 0 / kernel 0 of the current tile) and its address and mask.
    always_comb begin
        resync_s = beat & tile_start & ((p_r != P_ZERO) | (k_r != P_ZERO));
        if (resync_s) begin
            p_eff_s  = P_ZERO;
            k_eff_s  = P_ZERO;
            cb_eff_s = wt_base_r;
        end else begin
            p_eff_s  = p_r;
            k_eff_s  = k_r;
            cb_eff_s = ch_base_r;
        end
        pix_s     = {tt_r, p_eff_s};
        kidx_s    = {wt_r, k_eff_s};
        p_end_s   = (p_eff_s == P_MAX);
        k_end_s   = (k_eff_s == P_MAX);
        tt_end_s  = (tt_r == t_tiles_r - PIX_W'(1));
        wt_end_s  = (wt_r == w_tiles_r - KN_W'(1));
        addr      = cb_eff_s + ADDR_W'(pix_s);
        wr_mask   = (pix_s < {P_ZERO, op_r}) & (kidx_s < {P_ZERO, kn_r});
        last_beat = beat & p_end_s & k_end_s & tt_end_s & wt_end_s;
        misalign  = resync_s;
    end

    // Latch job geometry on load, then step counters and bases on every beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_r       <= P_ZERO;
            k_r       <= P_ZERO;
            tt_r      <= {PIX_W{1'b0}};
            wt_r      <= {KN_W{1'b0}};
            op_r      <= {PIX_W{1'b0}};
            kn_r      <= {KN_W{1'b0}};
            t_tiles_r <= {PIX_W{1'b0}};
            w_tiles_r <= {KN_W{1'b0}};
            ch_base_r <= {ADDR_W{1'b0}};
            wt_base_r <= {ADDR_W{1'b0}};
            step_n_r  <= {ADDR_W{1'b0}};
        end else if (load) begin
            p_r       <= P_ZERO;
            k_r       <= P_ZERO;
            tt_r      <= {PIX_W{1'b0}};
            wt_r      <= {KN_W{1'b0}};
            op_r      <= cfg_out_pixels;
            kn_r      <= cfg_kernel_nums;
            t_tiles_r <= pix_tiles(cfg_out_pixels);
            w_tiles_r <= kn_tiles(cfg_kernel_nums);
            ch_base_r <= cfg_base_addr;
            wt_base_r <= cfg_base_addr;
            step_n_r  <= ADDR_W'(cfg_out_pixels) << LOG2_N;
        end else if (beat) begin
            if (!p_end_s) begin
                p_r       <= p_eff_s + P_ONE;
                k_r       <= k_eff_s;
                ch_base_r <= cb_eff_s;
            end else if (!k_end_s) begin
                p_r       <= P_ZERO;
                k_r       <= k_eff_s + P_ONE;
                ch_base_r <= cb_eff_s + ADDR_W'(op_r);
            end else if (!tt_end_s) begin
                p_r       <= P_ZERO;
                k_r       <= P_ZERO;
                tt_r      <= tt_r + PIX_W'(1);
                ch_base_r <= wt_base_r;
            end else begin
                p_r       <= P_ZERO;
                k_r       <= P_ZERO;
                tt_r      <= {PIX_W{1'b0}};
                wt_r      <= wt_r + KN_W'(1);
                wt_base_r <= wt_base_r + step_n_r;
                ch_base_r <= wt_base_r + step_n_r;
            end
        end
    end

endmodule

// File: rtl/result_writer.sv
// result_writer: consumes the accumulated result stream, strips tensor and
// kernel padding and writes survivors channel-major into the output SRAM.
// Optional build macro RESULT_WRITER_RELU_EN clamps negative results to zero
// in the output register (same latency).
module result_writer
    import result_writer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [PIX_W-1:0]       cfg_out_pixels,
    input  logic [KN_W-1:0]        cfg_kernel_nums,
    input  logic [ADDR_W-1:0]      cfg_base_addr,
    input  logic [RESULT_SIZE-1:0] i_result,
    input  logic [3:0]             i_result_valid,
    input  logic                   i_conv_done,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [RESULT_SIZE-1:0] mem_wdata,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    rw_state_e               state_r, state_next_s;
    logic                    start_acc_s, err_set_s, beat_s;
    logic [ADDR_W-1:0]       addr_s;
    logic                    wr_mask_s, last_beat_s, misalign_s;
    logic [RESULT_SIZE-1:0]  wdata_s;
    logic                    mem_we_r, busy_r, done_r, err_r;
    logic [ADDR_W-1:0]       mem_addr_r;
    logic [RESULT_SIZE-1:0]  mem_wdata_r;
    logic                    unused_valid_s;

    assign beat_s         = i_result_valid[1] & (state_r == RUN);
    assign unused_valid_s = i_result_valid[0] ^ i_result_valid[3];

`ifdef RESULT_WRITER_RELU_EN
    assign wdata_s = relu_word(i_result);
`else
    assign wdata_s = i_result;
`endif

    result_addr_gen u_addr_gen (
        .clk             (clk),
        .rst             (rst),
        .load            (start_acc_s),
        .cfg_out_pixels  (cfg_out_pixels),
        .cfg_kernel_nums (cfg_kernel_nums),
        .cfg_base_addr   (cfg_base_addr),
        .beat            (beat_s),
        .tile_start      (i_result_valid[2]),
        .addr            (addr_s),
        .wr_mask         (wr_mask_s),
        .last_beat       (last_beat_s),
        .misalign        (misalign_s)
    );

    // Next-state and protocol-error detection.
    always_comb begin
        state_next_s = state_r;
        start_acc_s  = 1'b0;
        err_set_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    start_acc_s  = 1'b1;
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
                err_set_s = i_result_valid[1];
            end
            RUN: begin
                if (last_beat_s) begin
                    state_next_s = FLUSH;
                end else begin
                    state_next_s = RUN;
                end
                err_set_s = misalign_s | start | (i_conv_done & ~last_beat_s);
            end
            FLUSH: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Registered SRAM write port, status flags and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {RESULT_SIZE{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            mem_we_r <= beat_s & wr_mask_s;
            if (beat_s) begin
                mem_addr_r  <= addr_s;
                mem_wdata_r <= wdata_s;
            end
            busy_r <= (state_next_s == RUN);
            done_r <= (state_r == FLUSH);
            if (start_acc_s) begin
                err_r <= 1'b0;
            end else if (err_set_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule
